// File: rtl/skinny_sbox8_dom1_serial_ctrl.sv
// Serial sequencer for a masked SKINNY state: pushes one byte per pass through
// a single shared, non-pipelined DOM1 sbox8, fetching 8 fresh mask bits per byte.
module skinny_sbox8_dom1_serial_ctrl #(
  parameter int NBYTES = 16,
  parameter int SB_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   si1,
  input  logic [8*NBYTES-1:0]   si0,
  input  logic                  rnd_valid,
  input  logic [7:0]            rnd,
  output logic                  rnd_ready,
  output logic [7:0]            sb_si1,
  output logic [7:0]            sb_si0,
  output logic [7:0]            sb_r,
  input  logic [7:0]            sb_bo1,
  input  logic [7:0]            sb_bo0,
  output logic [8*NBYTES-1:0]   so1,
  output logic [8*NBYTES-1:0]   so0,
  output logic                  busy,
  output logic                  done
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNTW = $clog2(SB_LAT);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(SB_LAT - 1);

  // The sbox has negedge-clocked internal stages and needs >=4 stable cycles.
  generate
    if (SB_LAT < 4 || NBYTES < 1) begin : g_param_check
      $error("skinny_sbox8_dom1_serial_ctrl: need SB_LAT >= 4 and NBYTES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RND = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IDXW-1:0] r_idx;
  logic [CNTW-1:0] r_cnt;
  logic [7:0]      r_sb_si1;
  logic [7:0]      r_sb_si0;
  logic [7:0]      r_sb_r;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_so1_b [NBYTES];
  logic [7:0]      r_so0_b [NBYTES];

  logic            w_load;
  logic            w_accept;
  logic            w_capture;
  logic            w_last;
  logic [7:0]      w_cur_so1;
  logic [7:0]      w_cur_so0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    rnd_ready    = 1'b0;
    w_last       = (r_idx == LAST_IDX);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_WAIT_RND;
        end
      end
      S_WAIT_RND: begin
        rnd_ready = 1'b1;
        if (rnd_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == LAST_CNT) begin
          w_capture    = 1'b1;
          w_state_next = w_last ? S_IDLE : S_WAIT_RND;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_cur_so1 = r_so1_b[r_idx];
    w_cur_so0 = r_so0_b[r_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_capture && w_last;
      if (w_load) begin
        r_idx  <= '0;
        r_busy <= 1'b1;
      end else if (w_capture) begin
        if (w_last) begin
          r_busy <= 1'b0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_accept || w_capture) begin
        r_cnt <= '0;
      end else if (r_state == S_HOLD) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Sbox inputs return to zero after capture so consecutive bytes never
  // overwrite one share value with another directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_si1 <= '0;
      r_sb_si0 <= '0;
      r_sb_r   <= '0;
    end else if (w_accept) begin
      r_sb_si1 <= w_cur_so1;
      r_sb_si0 <= w_cur_so0;
      r_sb_r   <= rnd;
    end else if (w_capture) begin
      r_sb_si1 <= '0;
      r_sb_si0 <= '0;
      r_sb_r   <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      always_ff @(posedge clk) begin
        if (rst) begin
          r_so1_b[gi] <= '0;
          r_so0_b[gi] <= '0;
        end else if (w_load) begin
          r_so1_b[gi] <= si1[8*gi +: 8];
          r_so0_b[gi] <= si0[8*gi +: 8];
        end else if (w_capture && (r_idx == IDXW'(gi))) begin
          r_so1_b[gi] <= sb_bo1;
          r_so0_b[gi] <= sb_bo0;
        end
      end
      assign so1[8*gi +: 8] = r_so1_b[gi];
      assign so0[8*gi +: 8] = r_so0_b[gi];
    end
  endgenerate

  assign sb_si1 = r_sb_si1;
  assign sb_si0 = r_sb_si0;
  assign sb_r   = r_sb_r;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_skinny_sbox8_dom1_serial_ctrl.sv
// Scoreboard bench: driver pushes expected results per run, a negedge monitor
// checks protocol each cycle and the state shares whenever done pulses.
module tb_skinny_sbox8_dom1_serial_ctrl;
  localparam int NB  = 16;
  localparam int LAT = 4;
  localparam int W   = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] si1 = '0;
  logic [W-1:0] si0 = '0;
  logic         rnd_valid = 1'b0;
  logic [7:0]   rnd = 8'h00;
  logic         rnd_ready;
  logic [7:0]   sb_si1, sb_si0, sb_r, sb_bo1, sb_bo0;
  logic [W-1:0] so1, so0;
  logic         busy, done;

  skinny_sbox8_dom1_serial_ctrl #(.NBYTES(NB), .SB_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .si1(si1), .si0(si0),
    .rnd_valid(rnd_valid), .rnd(rnd), .rnd_ready(rnd_ready),
    .sb_si1(sb_si1), .sb_si0(sb_si0), .sb_r(sb_r),
    .sb_bo1(sb_bo1), .sb_bo0(sb_bo0),
    .so1(so1), .so0(so0), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bit-sliced SKINNY-128 S8 reference.
  function automatic logic [7:0] s8_mix(input logic [7:0] x);
    return ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
  endfunction
  function automatic logic [7:0] s8_perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction
  function automatic logic [7:0] s8(input logic [7:0] v);
    logic [7:0] x;
    x = s8_mix(v);  x = s8_perm(x);
    x = s8_mix(x);  x = s8_perm(x);
    x = s8_mix(x);  x = s8_perm(x);
    x = s8_mix(x);
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  // Behavioural masked sbox: share 1 is the fresh mask, share 0 completes it.
  assign sb_bo1 = sb_r;
  assign sb_bo0 = s8(sb_si0 ^ sb_si1) ^ sb_r;

  typedef struct {
    logic [W-1:0] a1;
    logic [W-1:0] a0;
    logic [W-1:0] xr;
    longint       lat;
    longint       t0;
  } exp_t;

  exp_t   q[$];
  int     vectors = 0;
  int     errors = 0;
  longint cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  int         k = 0;
  logic [7:0] rk [NB];
  logic [7:0] cap_r = 8'h00;
  logic       hold_d = 1'b0;
  logic       done_d = 1'b0;
  logic       rst_d = 1'b1;

  always @(negedge clk) begin
    logic hold;
    exp_t e;
    hold = busy && !rnd_ready;
    if (rst_d) begin
      check("reset_outputs", {so1, so0, sb_si1, sb_si0, sb_r, rnd_ready, busy, done}, '0);
      k = 0;
      hold = 1'b0;
    end else begin
      if (q.size() > 0 && cyc == q[0].t0) check("busy_after_start", busy, 1'b1);
      if (hold_d && !hold) begin
        if (k < NB) rk[k] = cap_r;
        k++;
      end
      if (done) begin
        check("done_single_cycle", done_d, 1'b0);
        check("busy_low_at_done", busy, 1'b0);
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending run");
        end else begin
          e = q.pop_front();
          check("latency", 256'(cyc - e.t0), 256'(e.lat));
          for (int b = 0; b < NB; b++)
            check($sformatf("byte%0d_{so1,xor}", b),
                  {so1[8*b +: 8], so0[8*b +: 8] ^ so1[8*b +: 8]},
                  {rk[b], e.xr[8*b +: 8]});
        end
        k = 0;
      end
      if (rnd_ready) begin
        check("wait_sb_zero", {sb_si1, sb_si0, sb_r}, '0);
        if (rnd_valid) cap_r = rnd;
      end
      if (hold && q.size() > 0 && k < NB)
        check("hold_inputs", {sb_si1, sb_si0, sb_r},
              {q[0].a1[8*k +: 8], q[0].a0[8*k +: 8], cap_r});
    end
    done_d = done;
    hold_d = hold;
    rst_d  = rst;
  end

  // Driver: one request; returns at the done cycle (or after an abort).
  task automatic run(input logic [W-1:0] a1, input logic [W-1:0] a0,
                     input logic [W-1:0] xr, input bit stall, input bit rand_rnd,
                     input bit ign, input int abort_rel, input bit b2b);
    longint t0;
    longint rel;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    si1 = a1;
    si0 = a0;
    start = 1'b1;
    t0 = cyc + 1;
    q.push_back('{a1: a1, a0: a0, xr: xr, lat: NB * (1 + LAT) + (stall ? 7 : 0), t0: t0});
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rel = cyc - t0;
      rnd_valid = !(stall && rel >= 15 && rel < 22);
      rnd = rand_rnd ? 8'($urandom) : 8'h5A;
      if (ign && rel == 30) begin
        start = 1'b1;
        si1 = ~a1;
      end
      if (abort_rel >= 0 && rel == abort_rel) begin
        rst = 1'b1;
        void'(q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (done) return;
    end
    vectors++;
    errors++;
    $display("FAIL run_timeout: got no done in 400 cycles, expected done");
  endtask

  initial begin
    logic [W-1:0] m1, m0, x;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // All-zero state, constant mask 0x5A.
    run('0, '0, {NB{8'h65}}, 0, 0, 0, -1, 0);

    // Complementary shares, random masks.
    run({NB{8'hFF}}, '0, {NB{8'hFF}}, 0, 1, 0, -1, 0);

    // Byte i = i behind random masks.
    for (int i = 0; i < NB; i++) begin
      m0[8*i +: 8] = 8'($urandom);
      m1[8*i +: 8] = m0[8*i +: 8] ^ 8'(i);
      x[8*i +: 8]  = s8(8'(i));
    end
    run(m1, m0, x, 0, 1, 0, -1, 0);

    // Same data with a 7-cycle PRNG stall before byte 3.
    run(m1, m0, x, 1, 1, 0, -1, 0);

    // Reset during byte 9 HOLD, then a clean run.
    run(m1, m0, x, 0, 1, 0, 47, 0);
    for (int i = 0; i < NB; i++) begin
      m0[8*i +: 8] = 8'($urandom);
      m1[8*i +: 8] = m0[8*i +: 8] ^ 8'(8'hA0 + i);
      x[8*i +: 8]  = s8(8'(8'hA0 + i));
    end
    run(m1, m0, x, 0, 1, 0, -1, 0);

    // Start while busy is ignored; start on the done cycle is accepted.
    run(m1, m0, x, 0, 1, 1, -1, 0);
    run({NB{8'h3C}}, {NB{8'h3C}}, {NB{8'h65}}, 0, 1, 0, -1, 1);

    repeat (5) @(posedge clk);
    if (q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL pending_runs: got %0d, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
